tcdm_filter_ctrl: RTL and testbench
===================================

Name: tcdm_filter_ctrl

Overview:
APB-programmable controller for the TCDM address filter. It holds a shadow rule table and commits it atomically to the filter. Before committing it drains in-flight transactions, so a filter never sees its rules change mid-transaction. It also captures protection violations (first address, count, overflow) and raises an interrupt. It sits beside the filter on the same port, with the APB slave on the SoC peripheral bus.

Parameters:
N_RULES, 8, number of filter rules; 1..16
ADDR_WIDTH, 32, filtered TCDM address width
APB_ADDR_WIDTH, 12, APB address width
OUTST_WIDTH, 4, outstanding-transaction counter width
ERR_CNT_WIDTH, 16, violation counter width

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
paddr_i  in  APB_ADDR_WIDTH  APB address
pwdata_i  in  32  APB write data
pwrite_i  in  1  APB write
psel_i  in  1  APB select
penable_i  in  1  APB enable
prdata_o  out  32  APB read data
pready_o  out  1  APB ready
pslverr_o  out  1  APB error
req_i  in  1  master request at filter input
gnt_i  in  1  grant at filter input (filter gnt_o)
r_valid_i  in  1  response valid at filter input (filter r_valid_o)
add_i  in  ADDR_WIDTH  request address at filter input
error_i  in  1  filter error_o
RULES_o  out  N_RULES x 32  active rule table to filter
filter_en_o  out  1  active filter enable
hold_o  out  1  when high, the top level forces the filter req_i low
irq_o  out  1  violation interrupt, level

Behaviour:
- Reset values: RULES_o = 0, filter_en_o = 0, hold_o = 0, irq_o = 0, prdata_o = 0, pslverr_o = 0. All shadow and status registers reset to 0. pready_o is a constant 1.
- APB access is zero-wait. A transfer happens on psel & penable. Write side effects occur in that cycle. prdata_o/pslverr_o are combinational from the registers.
- Register map (word offsets):
  - 0x00 CTRL: [0] en_shadow RW; [1] lock, RW1 (sticky until reset); [2] commit, W1 self-clearing; [3] irq_en RW.
  - 0x04 STATUS: [0] commit_busy RO; [1] err_valid W1C; [2] err_ovf W1C; [11:8] outstanding RO.
  - 0x08 ERR_ADDR RO. 0x0C ERR_CNT RO; any write clears it.
  - 0x40 + 4*i: RULE_SHADOW[i], RW, for i < N_RULES.
- pslverr_o = 1 for:
  - any access to an unmapped offset (read data 0);
  - a write to CTRL or RULE_SHADOW while lock = 1;
  - a write to RULE_SHADOW or a commit write while commit_busy = 1.
  An erroring write has no effect.
- Outstanding counter:
  - Increments on req_i & gnt_i; decrements on r_valid_i; unchanged when both occur.
  - hold_o is also asserted while the counter is at its maximum.
  - A decrement at zero is ignored.
- Commit FSM:
  - IDLE: a commit write moves to DRAIN. commit_busy = 1 in every state except IDLE.
  - DRAIN: hold_o = 1. Wait until outstanding = 0 and no req_i & gnt_i in the current cycle, then go to APPLY.
  - APPLY: one cycle. RULES_o <= RULE_SHADOW and filter_en_o <= en_shadow, visible the next cycle. Next state is IDLE; hold_o drops in the cycle after APPLY.
  - Commit latency with zero outstanding is 2 cycles from the APB write to RULES_o updated.
  - The first filter request under the new rules can be issued in cycle 3.
- Error capture:
  - On error_i: ERR_CNT increments, saturating at all-ones.
  - If err_valid = 0: ERR_ADDR <= add_i and err_valid <= 1.
  - Else: err_ovf <= 1 and ERR_ADDR is kept.
  - If an error_i and a W1C of err_valid occur in the same cycle, the set wins and ERR_ADDR captures the new address.
  - irq_o = err_valid & irq_en, registered (1-cycle delay).
- Reset mid-commit returns the FSM to IDLE and clears everything; the filter is disabled.

Decomposition:
- Package tcdm_filter_ctrl_pkg:
  - register offset constants;
  - CTRL/STATUS bit-index constants;
  - commit FSM state enum (IDLE, DRAIN, APPLY);
  - rule field widths (A 2, BASE 15, SIZE 14, S 1).
- One sub-module, tcdm_filter_err_capture: error latch, saturating counter, overflow flag and irq register.

Test Plan:
- Rule program and commit, idle bus: write RULE_SHADOW[0] = 0x0001_0003, write CTRL = 0x5 → commit_busy = 1 for 2 cycles, RULES_o[0] = 0x0001_0003, filter_en_o = 1, hold_o high for exactly 2 cycles.
- Commit with 3 outstanding reads: commit during traffic → hold_o stays 1 and RULES_o is unchanged until the third r_valid_i. APPLY occurs one cycle after that, and no req_i & gnt_i is seen while hold_o = 1.
- Errors: error_i pulses with add_i = 0x1C00_1000 then 0x1C00_2000 → ERR_ADDR = 0x1C00_1000, ERR_CNT = 2, err_ovf = 1. With irq_en = 1, irq_o rises 1 cycle after the first error.
- Simultaneous set/clear: W1C of err_valid in the same cycle as error_i with add_i = 0x1A10_0040 → err_valid stays 1, ERR_ADDR = 0x1A10_0040.
- Lock: set CTRL[1] = 1, then write RULE_SHADOW[2] → pslverr_o = 1 and the shadow is unchanged. A read of offset 0x20 → pslverr_o = 1, prdata_o = 0.
- Async reset asserted in DRAIN → all outputs 0 immediately, FSM IDLE after release, ERR_CNT = 0.

Source files
------------

// File: rtl/tcdm_filter_ctrl_pkg.sv
// Shared constants and types for the TCDM filter controller: register map,
// CTRL/STATUS bit positions, commit FSM states and rule field widths.
package tcdm_filter_ctrl_pkg;

    localparam logic [31:0] OFF_CTRL      = 32'h00;
    localparam logic [31:0] OFF_STATUS    = 32'h04;
    localparam logic [31:0] OFF_ERR_ADDR  = 32'h08;
    localparam logic [31:0] OFF_ERR_CNT   = 32'h0C;
    localparam logic [31:0] OFF_RULE_BASE = 32'h40;

    localparam int unsigned CTRL_EN     = 0;
    localparam int unsigned CTRL_LOCK   = 1;
    localparam int unsigned CTRL_COMMIT = 2;
    localparam int unsigned CTRL_IRQ_EN = 3;

    localparam int unsigned STAT_BUSY      = 0;
    localparam int unsigned STAT_ERR_VALID = 1;
    localparam int unsigned STAT_ERR_OVF   = 2;
    localparam int unsigned STAT_OUTST_LSB = 8;
    localparam int unsigned STAT_OUTST_W   = 4;

    localparam int unsigned RULE_A_W    = 2;
    localparam int unsigned RULE_BASE_W = 15;
    localparam int unsigned RULE_SIZE_W = 14;
    localparam int unsigned RULE_S_W    = 1;

    typedef enum logic [1:0] {
        StIdle,
        StDrain,
        StApply
    } commit_state_e;

endpackage

// File: rtl/tcdm_filter_ctrl_if.sv
// APB slave port plus the filter-side monitor/control signals of the controller.
interface tcdm_filter_ctrl_if #(
    parameter int unsigned N_RULES        = 8,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned APB_ADDR_WIDTH = 12
);
    logic [APB_ADDR_WIDTH-1:0] paddr_i;
    logic [31:0]               pwdata_i;
    logic                      pwrite_i;
    logic                      psel_i;
    logic                      penable_i;
    logic [31:0]               prdata_o;
    logic                      pready_o;
    logic                      pslverr_o;

    logic                      req_i;
    logic                      gnt_i;
    logic                      r_valid_i;
    logic [ADDR_WIDTH-1:0]     add_i;
    logic                      error_i;
    logic [N_RULES-1:0][31:0]  RULES_o;
    logic                      filter_en_o;
    logic                      hold_o;
    logic                      irq_o;

    modport slave (
        input  paddr_i, pwdata_i, pwrite_i, psel_i, penable_i,
        output prdata_o, pready_o, pslverr_o,
        input  req_i, gnt_i, r_valid_i, add_i, error_i,
        output RULES_o, filter_en_o, hold_o, irq_o
    );

    modport master (
        output paddr_i, pwdata_i, pwrite_i, psel_i, penable_i,
        input  prdata_o, pready_o, pslverr_o,
        output req_i, gnt_i, r_valid_i, add_i, error_i,
        input  RULES_o, filter_en_o, hold_o, irq_o
    );

endinterface

// File: rtl/tcdm_filter_err_capture.sv
// Protection-violation capture: first address, overflow flag, saturating count
// and the registered interrupt line.
module tcdm_filter_err_capture #(
    parameter int unsigned ADDR_WIDTH    = 32,
    parameter int unsigned ERR_CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     error,
    input  logic [ADDR_WIDTH-1:0]    add,
    input  logic                     clr_valid,
    input  logic                     clr_ovf,
    input  logic                     clr_cnt,
    input  logic                     irq_en,
    output logic                     err_valid,
    output logic                     err_ovf,
    output logic [ADDR_WIDTH-1:0]    err_addr,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt,
    output logic                     irq
);

    logic                     valid_q, valid_d;
    logic                     ovf_q, ovf_d;
    logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
    logic [ERR_CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                     irq_q;

    // Clears are applied first so a same-cycle error wins and recaptures.
    always_comb begin
        valid_d = valid_q & ~clr_valid;
        ovf_d   = ovf_q & ~clr_ovf;
        addr_d  = addr_q;
        cnt_d   = clr_cnt ? '0 : cnt_q;
        if (error) begin
            if (!valid_d) begin
                valid_d = 1'b1;
                addr_d  = add;
            end else begin
                ovf_d = 1'b1;
            end
            if (~&cnt_d) begin
                cnt_d = cnt_d + ERR_CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            addr_q  <= '0;
            cnt_q   <= '0;
            irq_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            irq_q   <= valid_d & irq_en;
        end
    end

    assign err_valid = valid_q;
    assign err_ovf   = ovf_q;
    assign err_addr  = addr_q;
    assign err_cnt   = cnt_q;
    assign irq       = irq_q;

endmodule

// File: rtl/tcdm_filter_ctrl.sv
// APB-programmable TCDM filter controller: shadow rule table with drained,
// atomic commit to the filter, outstanding tracking and violation capture.
module tcdm_filter_ctrl
    import tcdm_filter_ctrl_pkg::*;
#(
    parameter int unsigned N_RULES        = 8,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned APB_ADDR_WIDTH = 12,
    parameter int unsigned OUTST_WIDTH    = 4,
    parameter int unsigned ERR_CNT_WIDTH  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    tcdm_filter_ctrl_if.slave bus
);

    logic [31:0]              addr;
    logic                     xfer;
    logic                     is_ctrl, is_status, is_eaddr, is_ecnt, mapped;
    logic [N_RULES-1:0]       rule_sel;
    logic                     busy, wr_block, wr_ok, commit_go;
    logic [31:0]              rdata;

    logic                     en_shadow_q, lock_q, irq_en_q;
    logic [N_RULES-1:0][31:0] shadow_q, rules_q;
    logic                     filter_en_q;
    commit_state_e            state_q;
    logic [OUTST_WIDTH-1:0]   outst_q, outst_d;
    logic                     inc, outst_max;

    logic                     err_valid, err_ovf, irq;
    logic [ADDR_WIDTH-1:0]    err_addr;
    logic [ERR_CNT_WIDTH-1:0] err_cnt;

    assign addr      = 32'(bus.paddr_i);
    assign xfer      = bus.psel_i & bus.penable_i;
    assign is_ctrl   = (addr == OFF_CTRL);
    assign is_status = (addr == OFF_STATUS);
    assign is_eaddr  = (addr == OFF_ERR_ADDR);
    assign is_ecnt   = (addr == OFF_ERR_CNT);

    always_comb begin
        rule_sel = '0;
        for (int i = 0; i < N_RULES; i++) begin
            rule_sel[i] = (addr == OFF_RULE_BASE + 32'(4 * i));
        end
    end

    assign mapped    = is_ctrl | is_status | is_eaddr | is_ecnt | (|rule_sel);
    assign busy      = (state_q != StIdle);
    assign wr_block  = (is_ctrl & lock_q) | ((|rule_sel) & (lock_q | busy)) |
                       (is_ctrl & bus.pwdata_i[CTRL_COMMIT] & busy);
    assign wr_ok     = xfer & bus.pwrite_i & mapped & ~wr_block;
    assign commit_go = wr_ok & is_ctrl & bus.pwdata_i[CTRL_COMMIT];

    always_comb begin
        rdata = '0;
        if (is_ctrl) begin
            rdata[CTRL_EN]     = en_shadow_q;
            rdata[CTRL_LOCK]   = lock_q;
            rdata[CTRL_IRQ_EN] = irq_en_q;
        end
        if (is_status) begin
            rdata[STAT_BUSY]      = busy;
            rdata[STAT_ERR_VALID] = err_valid;
            rdata[STAT_ERR_OVF]   = err_ovf;
            rdata[STAT_OUTST_LSB +: STAT_OUTST_W] = STAT_OUTST_W'(outst_q);
        end
        if (is_eaddr) rdata = 32'(err_addr);
        if (is_ecnt)  rdata = 32'(err_cnt);
        for (int i = 0; i < N_RULES; i++) begin
            if (rule_sel[i]) rdata = shadow_q[i];
        end
    end

    assign bus.prdata_o  = (xfer & ~bus.pwrite_i) ? rdata : '0;
    assign bus.pready_o  = 1'b1;
    assign bus.pslverr_o = xfer & (~mapped | (bus.pwrite_i & wr_block));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_shadow_q <= 1'b0;
            lock_q      <= 1'b0;
            irq_en_q    <= 1'b0;
            shadow_q    <= '0;
        end else begin
            if (wr_ok && is_ctrl) begin
                en_shadow_q <= bus.pwdata_i[CTRL_EN];
                irq_en_q    <= bus.pwdata_i[CTRL_IRQ_EN];
                if (bus.pwdata_i[CTRL_LOCK]) lock_q <= 1'b1;
            end
            for (int i = 0; i < N_RULES; i++) begin
                if (wr_ok && rule_sel[i]) shadow_q[i] <= bus.pwdata_i;
            end
        end
    end

    assign inc       = bus.req_i & bus.gnt_i;
    assign outst_max = &outst_q;

    always_comb begin
        outst_d = outst_q;
        if (inc && !bus.r_valid_i && !outst_max) begin
            outst_d = outst_q + OUTST_WIDTH'(1);
        end else if (!inc && bus.r_valid_i && (outst_q != '0)) begin
            outst_d = outst_q - OUTST_WIDTH'(1);
        end
    end

    // Rules only change after the port has fully drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            rules_q     <= '0;
            filter_en_q <= 1'b0;
            outst_q     <= '0;
        end else begin
            outst_q <= outst_d;
            unique case (state_q)
                StIdle:  if (commit_go) state_q <= StDrain;
                StDrain: if ((outst_q == '0) && !inc) state_q <= StApply;
                StApply: begin
                    rules_q     <= shadow_q;
                    filter_en_q <= en_shadow_q;
                    state_q     <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.RULES_o     = rules_q;
    assign bus.filter_en_o = filter_en_q;
    assign bus.hold_o      = busy | outst_max;
    assign bus.irq_o       = irq;

    tcdm_filter_err_capture #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .ERR_CNT_WIDTH (ERR_CNT_WIDTH)
    ) u_err_capture (
        .clk       (clk),
        .rst_n     (rst_n),
        .error     (bus.error_i),
        .add       (bus.add_i),
        .clr_valid (wr_ok & is_status & bus.pwdata_i[STAT_ERR_VALID]),
        .clr_ovf   (wr_ok & is_status & bus.pwdata_i[STAT_ERR_OVF]),
        .clr_cnt   (wr_ok & is_ecnt),
        .irq_en    (irq_en_q),
        .err_valid (err_valid),
        .err_ovf   (err_ovf),
        .err_addr  (err_addr),
        .err_cnt   (err_cnt),
        .irq       (irq)
    );

endmodule

// File: tb/tb_tcdm_filter_ctrl.sv
// Directed bench for tcdm_filter_ctrl: APB accesses checked through a
// scoreboard queue, filter-side signals checked cycle by cycle.
module tb_tcdm_filter_ctrl;

    localparam int unsigned N_RULES = 8;

    localparam logic [11:0] A_CTRL   = 12'h000;
    localparam logic [11:0] A_STATUS = 12'h004;
    localparam logic [11:0] A_EADDR  = 12'h008;
    localparam logic [11:0] A_ECNT   = 12'h00C;
    localparam logic [11:0] A_RULE0  = 12'h040;
    localparam logic [11:0] A_RULE1  = 12'h044;
    localparam logic [11:0] A_RULE2  = 12'h048;
    localparam logic [11:0] A_HOLE   = 12'h020;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tcdm_filter_ctrl_if #(
        .N_RULES        (N_RULES),
        .ADDR_WIDTH     (32),
        .APB_ADDR_WIDTH (12)
    ) bus ();

    tcdm_filter_ctrl #(
        .N_RULES        (N_RULES),
        .ADDR_WIDTH     (32),
        .APB_ADDR_WIDTH (12),
        .OUTST_WIDTH    (4),
        .ERR_CNT_WIDTH  (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        string       tag;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   waited;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One zero-wait APB transfer; optionally fires error_i in the access cycle.
    task automatic apb(input logic wr, input logic [11:0] a, input logic [31:0] d,
                       input logic [31:0] exp_rd, input logic exp_err, input string tag,
                       input logic fire_err, input logic [31:0] eaddr);
        exp_t e;
        @(negedge clk);
        bus.psel_i    = 1'b1;
        bus.penable_i = 1'b0;
        bus.pwrite_i  = wr;
        bus.paddr_i   = a;
        bus.pwdata_i  = d;
        sb.push_back('{tag, exp_rd, exp_err});
        @(negedge clk);
        bus.penable_i = 1'b1;
        if (fire_err) begin
            bus.error_i = 1'b1;
            bus.add_i   = eaddr;
        end
        #1;
        e = sb.pop_front();
        if (!wr) check({e.tag, " rdata"}, bus.prdata_o, e.data);
        check({e.tag, " pslverr"}, 32'(bus.pslverr_o), 32'(e.err));
        @(posedge clk);
        #1;
        bus.psel_i    = 1'b0;
        bus.penable_i = 1'b0;
        bus.pwrite_i  = 1'b0;
        bus.error_i   = 1'b0;
    endtask

    task automatic apb_wr(input logic [11:0] a, input logic [31:0] d, input logic exp_err,
                          input string tag);
        apb(1'b1, a, d, 32'h0, exp_err, tag, 1'b0, 32'h0);
    endtask

    task automatic apb_rd(input logic [11:0] a, input logic [31:0] exp_rd, input logic exp_err,
                          input string tag);
        apb(1'b0, a, 32'h0, exp_rd, exp_err, tag, 1'b0, 32'h0);
    endtask

    task automatic err_pulse(input logic [31:0] eaddr);
        @(negedge clk);
        bus.error_i = 1'b1;
        bus.add_i   = eaddr;
        @(posedge clk);
        #1;
        bus.error_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.paddr_i   = '0;
        bus.pwdata_i  = '0;
        bus.pwrite_i  = 1'b0;
        bus.psel_i    = 1'b0;
        bus.penable_i = 1'b0;
        bus.req_i     = 1'b0;
        bus.gnt_i     = 1'b0;
        bus.r_valid_i = 1'b0;
        bus.add_i     = '0;
        bus.error_i   = 1'b0;

        // Reset state
        #2;
        for (int i = 0; i < N_RULES; i++) check("reset RULES_o", bus.RULES_o[i], 32'h0);
        check("reset filter_en", 32'(bus.filter_en_o), 32'd0);
        check("reset hold", 32'(bus.hold_o), 32'd0);
        check("reset irq", 32'(bus.irq_o), 32'd0);
        check("reset pready", 32'(bus.pready_o), 32'd1);
        check("reset prdata", bus.prdata_o, 32'h0);
        check("reset pslverr", 32'(bus.pslverr_o), 32'd0);
        #20 rst_n = 1'b1;

        // Program and commit on an idle bus
        apb_wr(A_RULE0, 32'h0001_0003, 1'b0, "wr rule0");
        apb_rd(A_RULE0, 32'h0001_0003, 1'b0, "rd rule0");
        check("pre-commit hold", 32'(bus.hold_o), 32'd0);
        apb_wr(A_CTRL, 32'h5, 1'b0, "commit idle");
        check("commit c1 hold", 32'(bus.hold_o), 32'd1);
        check("commit c1 rules", bus.RULES_o[0], 32'h0);
        @(posedge clk); #1;
        check("commit c2 hold", 32'(bus.hold_o), 32'd1);
        check("commit c2 rules", bus.RULES_o[0], 32'h0);
        @(posedge clk); #1;
        check("commit c3 hold", 32'(bus.hold_o), 32'd0);
        check("commit c3 rules", bus.RULES_o[0], 32'h0001_0003);
        check("commit c3 filter_en", 32'(bus.filter_en_o), 32'd1);

        // Commit with three outstanding reads
        @(negedge clk);
        bus.req_i = 1'b1;
        bus.gnt_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.req_i = 1'b0;
        bus.gnt_i = 1'b0;
        apb_wr(A_RULE1, 32'hAAAA_5555, 1'b0, "wr rule1");
        apb_wr(A_CTRL, 32'h5, 1'b0, "commit busy bus");
        check("drain hold", 32'(bus.hold_o), 32'd1);
        apb_wr(A_RULE2, 32'h1111_2222, 1'b1, "rule wr while busy");
        apb_wr(A_CTRL, 32'h5, 1'b1, "commit while busy");
        apb_rd(A_STATUS, 32'h0000_0301, 1'b0, "status draining");
        apb_rd(A_RULE2, 32'h0, 1'b0, "rule2 untouched");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus.r_valid_i = 1'b1;
            #1;
            check("drain hold at r_valid", 32'(bus.hold_o), 32'd1);
            check("drain rules at r_valid", bus.RULES_o[1], 32'h0);
            @(posedge clk); #1;
            bus.r_valid_i = 1'b0;
        end
        waited = 1;
        while (bus.hold_o && waited < 8) begin
            check("drain rules frozen", bus.RULES_o[1], 32'h0);
            @(posedge clk); #1;
            waited++;
        end
        check("drain hold released", 32'(bus.hold_o), 32'd0);
        check("drain exit latency", 32'(waited <= 3), 32'd1);
        check("drained rule1", bus.RULES_o[1], 32'hAAAA_5555);
        check("drained rule0", bus.RULES_o[0], 32'h0001_0003);
        @(negedge clk);
        bus.r_valid_i = 1'b1;
        @(posedge clk); #1;
        bus.r_valid_i = 1'b0;
        apb_rd(A_STATUS, 32'h0, 1'b0, "r_valid at zero");

        // Violation capture and interrupt
        apb_wr(A_CTRL, 32'h9, 1'b0, "irq_en");
        check("irq before err", 32'(bus.irq_o), 32'd0);
        err_pulse(32'h1C00_1000);
        check("irq after err", 32'(bus.irq_o), 32'd1);
        err_pulse(32'h1C00_2000);
        apb_rd(A_EADDR, 32'h1C00_1000, 1'b0, "err addr first");
        apb_rd(A_ECNT, 32'd2, 1'b0, "err cnt 2");
        apb_rd(A_STATUS, 32'h6, 1'b0, "status valid+ovf");

        // W1C of err_valid racing a new error
        apb(1'b1, A_STATUS, 32'h2, 32'h0, 1'b0, "w1c with err", 1'b1, 32'h1A10_0040);
        apb_rd(A_STATUS, 32'h6, 1'b0, "status after race");
        apb_rd(A_EADDR, 32'h1A10_0040, 1'b0, "err addr race");
        apb_rd(A_ECNT, 32'd3, 1'b0, "err cnt 3");
        apb_wr(A_STATUS, 32'h6, 1'b0, "w1c both");
        apb_wr(A_ECNT, 32'h0, 1'b0, "clr cnt");
        apb_rd(A_STATUS, 32'h0, 1'b0, "status cleared");
        apb_rd(A_ECNT, 32'h0, 1'b0, "cnt cleared");
        check("irq cleared", 32'(bus.irq_o), 32'd0);

        // Async reset while draining
        @(negedge clk);
        bus.req_i = 1'b1;
        bus.gnt_i = 1'b1;
        @(posedge clk); #1;
        bus.req_i = 1'b0;
        bus.gnt_i = 1'b0;
        err_pulse(32'h1C00_3000);
        apb_wr(A_CTRL, 32'hD, 1'b0, "commit before reset");
        check("pre-reset hold", 32'(bus.hold_o), 32'd1);
        check("pre-reset irq", 32'(bus.irq_o), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid-reset hold", 32'(bus.hold_o), 32'd0);
        check("mid-reset filter_en", 32'(bus.filter_en_o), 32'd0);
        check("mid-reset rule0", bus.RULES_o[0], 32'h0);
        check("mid-reset rule1", bus.RULES_o[1], 32'h0);
        check("mid-reset irq", 32'(bus.irq_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        apb_rd(A_STATUS, 32'h0, 1'b0, "status after reset");
        apb_rd(A_ECNT, 32'h0, 1'b0, "cnt after reset");
        apb_rd(A_CTRL, 32'h0, 1'b0, "ctrl after reset");
        apb_wr(A_RULE2, 32'h0000_0055, 1'b0, "rule2 idle write");

        // Lock and unmapped offsets
        apb_wr(A_CTRL, 32'hB, 1'b0, "set lock");
        apb_wr(A_RULE2, 32'h0000_1234, 1'b1, "rule wr locked");
        apb_rd(A_RULE2, 32'h0000_0055, 1'b0, "rule2 kept");
        apb_rd(A_HOLE, 32'h0, 1'b1, "unmapped read");
        apb_wr(A_CTRL, 32'h0, 1'b1, "ctrl wr locked");
        apb_rd(A_CTRL, 32'hB, 1'b0, "ctrl kept");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
